stack8_ctrl: RTL and testbench
==============================

# stack8_ctrl

LIFO controller that sits directly upstream of the 8-word x 16-bit `ram8` register file. It turns push/pop requests into `ram8` address/data/load drive and consumes `ram8`'s read port to return popped words. It tracks the stack pointer, full and empty state, and sticky error status. It also provides a multi-cycle clear sequence that zero-fills the RAM.

## Interface
Parameters:
- `WIDTH`, 16, data word width (matches `ram8`)
- `DEPTH`, 8, number of entries
- `AW`, 3, address width (log2 DEPTH)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `push`  in  1  push request, sampled each rising edge
- `pop`  in  1  pop request, sampled each rising edge
- `clear`  in  1  start zero-fill sequence
- `din`  in  WIDTH  push data
- `dout`  out  WIDTH  last popped word, registered
- `dout_valid`  out  1  one-cycle pulse, `dout` updated
- `count`  out  AW+1  entries held, 0..8
- `full`  out  1  `count == DEPTH`
- `empty`  out  1  `count == 0`
- `busy`  out  1  clear sequence in progress
- `err`  out  1  sticky overflow/underflow flag
- `ram_in`  out  WIDTH  to `ram8` in
- `ram_add`  out  AW  to `ram8` address
- `ram_load`  out  1  to `ram8` load
- `ram_out`  in  WIDTH  from `ram8` out (combinational read of `ram_add`)

## Operation
Reset state (`rst_n` low at a rising edge):
- Outputs: `dout=0`, `dout_valid=0`, `count=0`, `empty=1`, `full=0`, `busy=0`, `err=0`, state RUN.
- `ram_load` is forced to 0 while `rst_n` is low.
- RAM contents are untouched.

FSM has two states, RUN and CLR.

RUN, with `sp = count`:
- push only, not full: `ram_add=sp[AW-1:0]`, `ram_in=din`, `ram_load=1`; `sp <= sp+1`.
- pop only, not empty: `ram_add=sp-1`, `ram_load=0`; `dout <= ram_out`, `dout_valid <= 1`; `sp <= sp-1`.
- push+pop, not empty: replace top. `ram_add=sp-1`, `ram_in=din`, `ram_load=1`; `dout <= ram_out` (the old top); `sp` unchanged.
- push+pop, empty: bypass. `dout <= din`, `dout_valid <= 1`, no RAM write, `sp` stays 0.
- push only, full: overflow. No write, `err <= 1`.
- pop only, empty: underflow. `dout` holds, no pulse, `err <= 1`.
- `clear` has priority over push/pop. It goes to CLR with `clr_idx=0` and ignores push/pop in that cycle.
- Idle: `ram_add=0`, `ram_in=0`, `ram_load=0`.

CLR:
- Each cycle: `ram_add=clr_idx`, `ram_in=0`, `ram_load=1`, `busy=1`.
- After the write at `clr_idx=7`: `sp <= 0`, `err <= 0`, return to RUN.
- push/pop/clear are ignored in CLR, with no error.
- Reset in CLR aborts to RUN; the partial clear is left in RAM.

Width rules:
- `sp` is AW+1 bits and never wraps; it saturates by refusal at 0 and DEPTH.
- `ram_add` is the low AW bits of `sp` or `sp-1`.

## Timing
- RAM drive (`ram_add`, `ram_in`, `ram_load`) is combinational from state, `sp`, `push`, `pop`, and `din`. `ram8` commits the write at the same rising edge that samples the request.
- `count`, `full`, and `empty` reflect a request one cycle after it is sampled.
- Pop latency is 1 cycle: `dout` and `dout_valid` are valid in the cycle after `pop` is sampled.
- Back-to-back push or pop every cycle is supported at full rate.
- Replace-top reads the pre-edge `ram_out`, so it returns the old value. `ram8` semantics guarantee this.
- `clear` takes 8 cycles of `busy=1`. RUN resumes on the 9th cycle, with `count=0` visible that cycle.
- `err` sets one cycle after the offending request and clears only on reset or at the end of CLR.

## Structure
- Shared constants header `stack8_defs` holds WIDTH, DEPTH, AW, and the state encodings (RUN=0, CLR=1).
- One sub-module, `stack8_ptr`: the AW+1-bit up/down stack pointer with inc/dec/zero controls and `full`/`empty` decode.
- The top level holds the FSM, the `clr_idx` counter, RAM drive muxing, and the `dout`/`err` registers.
- Bench instantiates `stack8_ctrl` wired to a real `ram8`.

## Test plan
- Push `din = 123, 246, 369` on consecutive cycles, then pop 3 -> `dout` pulses 369, 246, 123; `count` goes 3 to 0; `empty=1`.
- Push 8 words, then push 0xBEEF -> `full=1`, `err=1` next cycle, RAM unchanged, `count=8`.
- From empty, pop -> `err=1`, no `dout_valid`. From empty, push+pop with `din=0x00AA` -> `dout=0x00AA`, `count=0`, no RAM write.
- With `count=2` and top=0x1111, push+pop `din=0x2222` -> `dout=0x1111`, `count=2`; next pop returns 0x2222.
- Fill with nonzero data, assert `clear` -> `busy` high 8 cycles, `ram_add` walks 0..7 with `ram_in=0`, `err=0`; after clear, push 8 and pop 8 match.
- Assert `rst_n=0` during the 4th clear cycle -> next cycle `busy=0`, `count=0`, `ram_load=0`. Addresses 0..2 or 0..3 are zeroed, the rest retain their data.

Source files
------------

// File: rtl/stack8_defs.sv
// stack8_defs: shared sizes and FSM encodings for the stack8 controller.
package stack8_defs;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  // Two-state controller: normal push/pop service, or the zero-fill walk.
  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_CLR = 1'b1;
endpackage

// File: rtl/ram8.sv
// ram8: 8-word register file, registered write on load, combinational read.
module ram8
  import stack8_defs::*;
#(
  parameter int W = WIDTH,
  parameter int N = DEPTH,
  parameter int A = AW
) (
  input  logic         clk,
  input  logic [W-1:0] in,
  input  logic [A-1:0] address,
  input  logic         load,
  output logic [W-1:0] out
);
  logic [W-1:0] mem [N];

  // Commit a write at the edge that samples load.
  always_ff @(posedge clk) begin
    if (load) mem[address] <= in;
  end

  assign out = mem[address];
endmodule

// File: rtl/stack8_ptr.sv
// stack8_ptr: saturating up/down stack pointer with full/empty decode.
module stack8_ptr
  import stack8_defs::*;
#(
  parameter int DEPTH_P = DEPTH,
  parameter int AW_P    = AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  input  logic          zero,
  output logic [AW_P:0] sp,
  output logic          full,
  output logic          empty
);
  localparam logic [AW_P:0] SP_MAX = (AW_P+1)'(DEPTH_P);

  // Pointer update; callers only raise inc/dec when it cannot over/underflow,
  // the full/empty guards here keep it from wrapping regardless.
  always_ff @(posedge clk) begin
    if (!rst_n)                 sp <= '0;
    else if (zero)              sp <= '0;
    else if (inc && !dec && !full)  sp <= sp + 1'b1;
    else if (dec && !inc && !empty) sp <= sp - 1'b1;
  end

  assign full  = (sp == SP_MAX);
  assign empty = (sp == '0);
endmodule

// File: rtl/stack8_ctrl.sv
// stack8_ctrl: LIFO controller driving an external ram8 register file.
module stack8_ctrl
  import stack8_defs::*;
#(
  parameter int WIDTH_P = WIDTH,
  parameter int DEPTH_P = DEPTH,
  parameter int AW_P    = AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  logic [WIDTH_P-1:0] din,
  output logic [WIDTH_P-1:0] dout,
  output logic               dout_valid,
  output logic [AW_P:0]      count,
  output logic               full,
  output logic               empty,
  output logic               busy,
  output logic               err,
  output logic [WIDTH_P-1:0] ram_in,
  output logic [AW_P-1:0]    ram_add,
  output logic               ram_load,
  input  logic [WIDTH_P-1:0] ram_out
);
  localparam logic [AW_P-1:0] CLR_LAST = AW_P'(DEPTH_P-1);

  logic [0:0]      state;
  logic [AW_P-1:0] clr_idx;
  logic [AW_P:0]   sp, sp_m1;
  logic            run, req_push, req_pop, req_both;
  logic            do_push, do_pop, do_repl, do_byp, ovf, unf, clr_done;
  logic            load_raw;

  assign run      = (state == ST_RUN);
  assign req_push = run && !clear && push && !pop;
  assign req_pop  = run && !clear && pop && !push;
  assign req_both = run && !clear && push && pop;

  assign do_push  = req_push && !full;
  assign ovf      = req_push && full;
  assign do_pop   = req_pop && !empty;
  assign unf      = req_pop && empty;
  assign do_repl  = req_both && !empty;
  assign do_byp   = req_both && empty;
  assign clr_done = !run && (clr_idx == CLR_LAST);

  assign sp_m1 = sp - 1'b1;

  stack8_ptr #(.DEPTH_P(DEPTH_P), .AW_P(AW_P)) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (do_push),
    .dec   (do_pop),
    .zero  (clr_done),
    .sp    (sp),
    .full  (full),
    .empty (empty)
  );

  assign count = sp;
  assign busy  = !run;

  // RAM drive: zero-fill walk in CLR, else top-of-stack address per request.
  always_comb begin
    ram_add  = '0;
    ram_in   = '0;
    load_raw = 1'b0;
    if (!run) begin
      ram_add  = clr_idx;
      load_raw = 1'b1;
    end else if (do_push) begin
      ram_add  = sp[AW_P-1:0];
      ram_in   = din;
      load_raw = 1'b1;
    end else if (do_pop) begin
      ram_add  = sp_m1[AW_P-1:0];
    end else if (do_repl) begin
      ram_add  = sp_m1[AW_P-1:0];
      ram_in   = din;
      load_raw = 1'b1;
    end
  end

  // A reset edge must never commit a write, even mid-clear.
  assign ram_load = load_raw && rst_n;

  // FSM and zero-fill index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      clr_idx <= '0;
    end else if (run) begin
      clr_idx <= '0;
      if (clear) state <= ST_CLR;
    end else begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_done) state <= ST_RUN;
    end
  end

  // Popped data: ram_out is the pre-edge top; bypass forwards din directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (do_pop || do_repl) begin
        dout       <= ram_out;
        dout_valid <= 1'b1;
      end else if (do_byp) begin
        dout       <= din;
        dout_valid <= 1'b1;
      end
    end
  end

  // Sticky error: set on refused request, cleared only by reset or clear.
  always_ff @(posedge clk) begin
    if (!rst_n)          err <= 1'b0;
    else if (clr_done)   err <= 1'b0;
    else if (ovf || unf) err <= 1'b1;
  end
endmodule

// File: tb/tb_stack8_ctrl.sv
// Directed bench for stack8_ctrl wired to a ram8 instance.
module tb_stack8_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, push, pop, clear;
  logic [15:0] din, dout, ram_in, ram_out;
  logic [2:0]  ram_add;
  logic [3:0]  count;
  logic        dout_valid, full, empty, busy, err, ram_load;
  int          nvec = 0;
  int          nfail = 0;

  always #5 clk = ~clk;

  stack8_ctrl dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clear(clear),
    .din(din), .dout(dout), .dout_valid(dout_valid), .count(count),
    .full(full), .empty(empty), .busy(busy), .err(err),
    .ram_in(ram_in), .ram_add(ram_add), .ram_load(ram_load), .ram_out(ram_out)
  );

  ram8 u_ram (.clk(clk), .in(ram_in), .address(ram_add), .load(ram_load), .out(ram_out));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; clear = 1'b0; din = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b1; pop = 1'b0; clear = 1'b0; din = 16'h1234;
    #1;
    chk("rst_load_forced", {31'd0, ram_load}, 32'd0);
    tick(); tick();
    chk("rst_dout", {16'd0, dout}, 32'd0);
    chk("rst_dv", {31'd0, dout_valid}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_flags", {28'd0, empty, full, busy, err}, 32'b1000);
    push = 1'b0; rst_n = 1'b1;
    tick();

    // push 123, 246, 369 then pop three
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; din = 16'(123 * (i + 1));
      #1;
      chk("push_drive", {12'd0, ram_load, ram_add, ram_in}, {12'd0, 1'b1, 3'(i), 16'(123 * (i + 1))});
      tick();
      chk("push_count", {28'd0, count}, 32'(i + 1));
    end
    push = 1'b0; pop = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      tick();
      chk("pop_dv", {31'd0, dout_valid}, 32'd1);
      chk("pop_dout", {16'd0, dout}, 32'(123 * (i + 1)));
      chk("pop_count", {28'd0, count}, 32'(i));
    end
    pop = 1'b0;
    tick();
    chk("pop_done_dv_empty", {30'd0, dout_valid, empty}, 32'b01);

    // fill to full, then overflow
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; din = 16'h1000 + 16'(i);
      tick();
    end
    chk("fill_full", {28'd0, count}, 32'd8);
    chk("fill_flag", {31'd0, full}, 32'd1);
    din = 16'hBEEF;
    #1;
    chk("ovf_no_load", {31'd0, ram_load}, 32'd0);
    tick();
    push = 1'b0;
    chk("ovf_err", {31'd0, err}, 32'd1);
    chk("ovf_count", {28'd0, count}, 32'd8);
    chk("ovf_ram7", {16'd0, u_ram.mem[7]}, 32'h1007);

    // underflow from empty
    do_reset();
    chk("rerst_err", {31'd0, err}, 32'd0);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("unf_err", {31'd0, err}, 32'd1);
    chk("unf_dv", {31'd0, dout_valid}, 32'd0);
    chk("unf_dout_hold", {16'd0, dout}, 32'd0);

    // bypass push+pop on empty
    do_reset();
    push = 1'b1; pop = 1'b1; din = 16'h00AA;
    #1;
    chk("byp_no_load", {31'd0, ram_load}, 32'd0);
    tick();
    push = 1'b0; pop = 1'b0;
    chk("byp_dout", {15'd0, dout_valid, dout}, {15'd0, 1'b1, 16'h00AA});
    chk("byp_count", {28'd0, count}, 32'd0);
    chk("byp_err", {31'd0, err}, 32'd0);

    // replace-top with count=2
    push = 1'b1; din = 16'h3333; tick();
    din = 16'h1111; tick();
    pop = 1'b1; din = 16'h2222; tick();
    push = 1'b0;
    chk("repl_dout", {15'd0, dout_valid, dout}, {15'd0, 1'b1, 16'h1111});
    chk("repl_count", {28'd0, count}, 32'd2);
    tick();
    chk("repl_pop1", {16'd0, dout}, 32'h2222);
    tick();
    chk("repl_pop2", {16'd0, dout}, 32'h3333);
    pop = 1'b0;
    chk("repl_empty", {28'd0, count}, 32'd0);

    // fill, overflow to set err, then clear
    push = 1'b1;
    for (int i = 0; i < 9; i++) begin
      din = 16'h5000 + 16'(i);
      tick();
    end
    chk("pre_clr_err", {31'd0, err}, 32'd1);
    clear = 1'b1;
    #1;
    chk("clr_req_no_load", {31'd0, ram_load}, 32'd0);
    tick();
    clear = 1'b0; pop = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("clr_busy", {31'd0, busy}, 32'd1);
      chk("clr_drive", {12'd0, ram_load, ram_add, ram_in}, {12'd0, 1'b1, 3'(k), 16'd0});
      tick();
    end
    push = 1'b0; pop = 1'b0;
    chk("clr_done_busy", {31'd0, busy}, 32'd0);
    chk("clr_done_count", {28'd0, count}, 32'd0);
    chk("clr_done_err", {31'd0, err}, 32'd0);
    for (int i = 0; i < 8; i++) chk("clr_mem", {16'd0, u_ram.mem[i]}, 32'd0);
    push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 16'h7000 + 16'(i);
      tick();
    end
    push = 1'b0; pop = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick();
      chk("post_clr_pop", {15'd0, dout_valid, dout}, {15'd0, 1'b1, 16'h7000 + 16'(i)});
    end
    pop = 1'b0;

    // reset during the 4th clear cycle
    push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 16'h9000 + 16'(i);
      tick();
    end
    push = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("abort_load_forced", {31'd0, ram_load}, 32'd0);
    tick();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_count", {28'd0, count}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++)
      chk("abort_mem", {16'd0, u_ram.mem[i]}, (i < 3) ? 32'd0 : 32'h9000 + 32'(i));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
